pipe_ctrl_tracker: RTL and testbench

//  Pipelined successor to the single-cycle control decoder. Decodes each ID-stage

---
 rtl/pipe_ctrl_tracker.sv | 141 ++++++++++++++
 tb/tb_pipe_ctrl_tracker.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_tracker.sv
// pipe_ctrl_tracker
//   Decodes the ID-stage instruction (5-bit opcode ISA) into a control bundle
//   and carries it through the ID/EX, EX/MEM and MEM/WB registers. It detects
//   RAW hazards against older in-flight writers, inserts bubbles on stalls,
//   squashes the ID instruction on flush, and latches a sticky halt.
// Ports
//   clk, rst_n             clock (rising edge), async active-low reset
//   id_valid, id_instr     ID instruction: [15:11] op, [10:8] rs, [7:5] rt, [4:2] rd
//   flush                  taken branch/jump in EX; discard the ID instruction
//   id_ready, stall        ID accept / hazard stall
//   ex_*, mem_*, wb_*      per-stage valid, control bits and destination register
//   halted                 sticky, set once a halt reaches MEM/WB
module pipe_ctrl_tracker #(
  parameter int REG_ADDR_W = 3,
  parameter bit FWD_MEM    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [15:0]           id_instr,
  input  logic                  flush,
  output logic                  id_ready,
  output logic                  stall,
  output logic                  ex_valid,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic [REG_ADDR_W-1:0] ex_dest,
  output logic                  mem_valid,
  output logic                  mem_reg_write,
  output logic                  mem_mem_read,
  output logic                  mem_mem_write,
  output logic [REG_ADDR_W-1:0] mem_dest,
  output logic                  wb_valid,
  output logic                  wb_reg_write,
  output logic [REG_ADDR_W-1:0] wb_dest,
  output logic                  halted
);
  localparam int STAGES = 3;

  typedef struct packed {
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  halt;
    logic [REG_ADDR_W-1:0] dest;
  } ctrl_t;

  logic [4:0]            op;
  logic [REG_ADDR_W-1:0] rs, rt, rd;
  logic                  unused;

  assign op     = id_instr[15:11];
  assign rs     = REG_ADDR_W'(id_instr[10:8]);
  assign rt     = REG_ADDR_W'(id_instr[7:5]);
  assign rd     = REG_ADDR_W'(id_instr[4:2]);
  assign unused = ^id_instr[1:0];

  // ---------------- decode ----------------
  ctrl_t dec;
  logic  uses_rs, uses_rt;

  always_comb begin
    dec           = '0;
    dec.reg_write = !(op[4:2] == 3'b000 || op == 5'b10000 ||
                      op[4:2] == 3'b011 || op[4:1] == 4'b0010);
    dec.mem_read  = (op == 5'b10001);
    dec.mem_write = (op == 5'b10000) || (op == 5'b10011);
    dec.halt      = (op == 5'b00000);
    if (op == 5'b11001 || op[4:1] == 4'b1101 || op[4:2] == 3'b111)
      dec.dest = rd;
    else if (op[4:2] == 3'b001)
      dec.dest = '1;                      // link-style ops write R7
    else if (op == 5'b10011 || op == 5'b11000 || op == 5'b10010)
      dec.dest = rs;
    else
      dec.dest = rt;
    uses_rs = !(op inside {5'b00000, 5'b00001, 5'b00100, 5'b00110, 5'b11000});
    uses_rt = (op[4:1] == 4'b1101) || (op[4:2] == 3'b111) ||
              (op == 5'b10000) || (op == 5'b10011);
  end

  // ---------------- pipeline state ----------------
  ctrl_t               ex_c, mem_c;
  logic                wb_rw;
  logic [REG_ADDR_W-1:0] wb_d;
  logic [STAGES:1]     vld_pipe;
  logic                halt_pend, halted_q;

  // ---------------- hazard ----------------
  logic hit_ex, hit_mem, raw, ld;

  assign hit_ex  = vld_pipe[1] & ex_c.reg_write &
                   ((uses_rs & (rs == ex_c.dest)) | (uses_rt & (rt == ex_c.dest)));
  assign hit_mem = vld_pipe[2] & mem_c.reg_write &
                   ((uses_rs & (rs == mem_c.dest)) | (uses_rt & (rt == mem_c.dest)));
  // With forwarding only a load in EX cannot supply its result in time.
  assign raw      = FWD_MEM ? (hit_ex & ex_c.mem_read) : (hit_ex | hit_mem);
  assign stall    = id_valid & raw & ~flush & ~halt_pend;
  assign id_ready = ~stall & ~halt_pend;
  assign ld       = id_valid & ~flush & ~halt_pend & ~stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      ex_c      <= '0;
      mem_c     <= '0;
      wb_rw     <= 1'b0;
      wb_d      <= '0;
      halt_pend <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      // EX->MEM->WB always advance; only ID/EX chooses between load and bubble.
      vld_pipe <= {vld_pipe[STAGES-1:1], ld};
      ex_c     <= ld ? dec : '0;
      mem_c    <= ex_c;
      wb_rw    <= mem_c.reg_write;
      wb_d     <= mem_c.dest;
      if (ld && dec.halt)
        halt_pend <= 1'b1;
      if (vld_pipe[2] && mem_c.halt)
        halted_q <= 1'b1;
    end
  end

  assign ex_valid      = vld_pipe[1];
  assign ex_reg_write  = ex_c.reg_write;
  assign ex_mem_read   = ex_c.mem_read;
  assign ex_mem_write  = ex_c.mem_write;
  assign ex_dest       = ex_c.dest;
  assign mem_valid     = vld_pipe[2];
  assign mem_reg_write = mem_c.reg_write;
  assign mem_mem_read  = mem_c.mem_read;
  assign mem_mem_write = mem_c.mem_write;
  assign mem_dest      = mem_c.dest;
  assign wb_valid      = vld_pipe[3];
  assign wb_reg_write  = wb_rw;
  assign wb_dest       = wb_d;
  assign halted        = halted_q;

endmodule

// File: tb/tb_pipe_ctrl_tracker.sv
// Bench for pipe_ctrl_tracker: a vector table drives the FWD_MEM=1 instance,
// expected WB results go through a scoreboard queue; hand sequences cover
// halt drain, async reset and the FWD_MEM=0 double stall.
module tb_pipe_ctrl_tracker;
  logic        clk = 1'b0, rst_n = 1'b0, id_valid = 1'b0, flush = 1'b0;
  logic [15:0] id_instr = '0;

  logic       id_ready, stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [2:0] ex_dest, mem_dest, wb_dest;
  logic       mem_valid, mem_reg_write, mem_mem_read, mem_mem_write;
  logic       wb_valid, wb_reg_write, halted;

  logic       d0_id_ready, d0_stall, d0_ex_valid, d0_ex_reg_write, d0_ex_mem_read, d0_ex_mem_write;
  logic [2:0] d0_ex_dest, d0_mem_dest, d0_wb_dest;
  logic       d0_mem_valid, d0_mem_reg_write, d0_mem_mem_read, d0_mem_mem_write;
  logic       d0_wb_valid, d0_wb_reg_write, d0_halted;

  always #5 clk = ~clk;

  pipe_ctrl_tracker #(.REG_ADDR_W(3), .FWD_MEM(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr), .flush(flush),
    .id_ready(id_ready), .stall(stall),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_dest(ex_dest),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_dest(mem_dest),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_dest(wb_dest), .halted(halted));

  pipe_ctrl_tracker #(.REG_ADDR_W(3), .FWD_MEM(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr), .flush(flush),
    .id_ready(d0_id_ready), .stall(d0_stall),
    .ex_valid(d0_ex_valid), .ex_reg_write(d0_ex_reg_write), .ex_mem_read(d0_ex_mem_read),
    .ex_mem_write(d0_ex_mem_write), .ex_dest(d0_ex_dest),
    .mem_valid(d0_mem_valid), .mem_reg_write(d0_mem_reg_write), .mem_mem_read(d0_mem_mem_read),
    .mem_mem_write(d0_mem_mem_write), .mem_dest(d0_mem_dest),
    .wb_valid(d0_wb_valid), .wb_reg_write(d0_wb_reg_write), .wb_dest(d0_wb_dest),
    .halted(d0_halted));

  typedef struct {
    logic v; logic [15:0] ins; logic fl;
    logic st; logic rdy; logic rw; logic mr; logic mw; logic [2:0] dest;
  } vec_t;
  typedef struct { logic rw; logic [2:0] dest; logic hlt; int due; } sb_t;

  sb_t  q[$];
  vec_t tbl[$];
  int   cnt = 0, checks = 0, errors = 0;
  logic exp_halted = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cnt);
    end
  endtask

  function automatic logic [15:0] ins(input logic [4:0] op, input logic [2:0] rs,
                                      input logic [2:0] rt, input logic [2:0] rd);
    return {op, rs, rt, rd, 2'b00};
  endfunction

  function automatic vec_t mkv(input logic v, input logic [15:0] i, input logic fl,
                               input logic st, input logic rdy, input logic rw,
                               input logic mr, input logic mw, input logic [2:0] dest);
    vec_t t;
    t.v = v; t.ins = i; t.fl = fl; t.st = st; t.rdy = rdy;
    t.rw = rw; t.mr = mr; t.mw = mw; t.dest = dest;
    return t;
  endfunction

  function automatic logic [31:0] allout();
    return 32'({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_dest,
                mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_dest,
                wb_valid, wb_reg_write, wb_dest, halted});
  endfunction

  task automatic sb_check();
    sb_t e;
    if (q.size() > 0 && q[0].due == cnt) begin
      e = q.pop_front();
      chk("wb_valid", wb_valid, 1);
      chk("wb_bundle", {wb_reg_write, wb_dest}, {e.rw, e.dest});
      if (e.hlt) exp_halted = 1'b1;
    end else begin
      chk("wb_idle", wb_valid, 0);
    end
    chk("halted", halted, exp_halted);
  endtask

  // One clock: drive, check combinational outputs at negedge, check EX and
  // scoreboard just after the rising edge.
  task automatic cyc(input vec_t t);
    logic acc;
    sb_t  e;
    id_valid = t.v; id_instr = t.ins; flush = t.fl;
    @(negedge clk);
    chk("stall", stall, t.st);
    chk("id_ready", id_ready, t.rdy);
    acc = t.v & ~t.fl & t.rdy;
    if (acc) begin
      e.rw = t.rw; e.dest = t.dest; e.hlt = (t.ins[15:11] == 5'd0); e.due = cnt + 3;
      q.push_back(e);
    end
    @(posedge clk); cnt++; #1;
    chk("ex_valid", ex_valid, acc);
    if (acc) chk("ex_bundle", {ex_reg_write, ex_mem_read, ex_mem_write, ex_dest},
                 {t.rw, t.mr, t.mw, t.dest});
    sb_check();
  endtask

  // Asserts reset between clock edges and checks outputs clear with no edge.
  task automatic do_reset();
    id_valid = 1'b0; flush = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("reset_outs", allout(), 0);
    chk("reset_ready", id_ready, 1);
    q.delete();
    exp_halted = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); cnt++; #1;
  endtask

  vec_t idle;

  initial begin
    idle = mkv(0, 16'h0000, 0, 0, 1, 0, 0, 0, 0);
    do_reset();

    //            v  instr                        fl st rdy rw mr mw dest
    tbl.push_back(mkv(1, ins(5'b01000, 0, 1, 0), 0, 0, 1, 1, 0, 0, 1)); // ADDI r1
    tbl.push_back(mkv(1, ins(5'b11011, 1, 2, 3), 0, 0, 1, 1, 0, 0, 3)); // ADD r3: forwarded
    tbl.push_back(mkv(1, ins(5'b10001, 5, 2, 0), 0, 0, 1, 1, 1, 0, 2)); // LD r2
    tbl.push_back(mkv(1, ins(5'b11011, 4, 2, 6), 0, 1, 0, 0, 0, 0, 0)); // load-use on rt
    tbl.push_back(mkv(1, ins(5'b11011, 4, 2, 6), 0, 0, 1, 1, 0, 0, 6)); // retry
    tbl.push_back(mkv(1, ins(5'b10000, 1, 6, 0), 0, 0, 1, 0, 0, 1, 6)); // ST
    tbl.push_back(mkv(1, ins(5'b10011, 2, 3, 0), 0, 0, 1, 1, 0, 1, 2)); // dest rs
    tbl.push_back(mkv(1, ins(5'b00100, 1, 1, 1), 0, 0, 1, 0, 0, 0, 7)); // R7, no write
    tbl.push_back(mkv(1, ins(5'b00110, 1, 1, 1), 0, 0, 1, 1, 0, 0, 7)); // R7 link
    tbl.push_back(mkv(1, ins(5'b01100, 3, 4, 0), 0, 0, 1, 0, 0, 0, 4));
    tbl.push_back(mkv(1, ins(5'b11001, 1, 1, 5), 0, 0, 1, 1, 0, 0, 5));
    tbl.push_back(mkv(1, ins(5'b11100, 0, 0, 2), 0, 0, 1, 1, 0, 0, 2));
    tbl.push_back(mkv(1, ins(5'b10010, 6, 0, 0), 0, 0, 1, 1, 0, 0, 6));
    tbl.push_back(mkv(1, ins(5'b11000, 3, 0, 0), 0, 0, 1, 1, 0, 0, 3));
    tbl.push_back(mkv(1, ins(5'b00001, 0, 5, 0), 0, 0, 1, 0, 0, 0, 5));
    tbl.push_back(idle);
    tbl.push_back(mkv(1, ins(5'b10001, 0, 5, 0), 0, 0, 1, 1, 1, 0, 5)); // LD r5
    tbl.push_back(mkv(1, ins(5'b11011, 5, 1, 2), 1, 0, 1, 0, 0, 0, 0)); // load-use + flush
    tbl.push_back(idle);
    tbl.push_back(mkv(1, ins(5'b10001, 1, 3, 0), 0, 0, 1, 1, 1, 0, 3)); // LD r3
    tbl.push_back(mkv(1, ins(5'b01000, 0, 3, 0), 0, 0, 1, 1, 0, 0, 3)); // rt not a source
    tbl.push_back(mkv(1, ins(5'b10001, 0, 4, 0), 0, 0, 1, 1, 1, 0, 4)); // LD r4
    tbl.push_back(mkv(1, ins(5'b11000, 4, 0, 0), 0, 0, 1, 1, 0, 0, 4)); // rs not a source
    tbl.push_back(mkv(1, ins(5'b10001, 0, 7, 0), 0, 0, 1, 1, 1, 0, 7)); // LD r7
    tbl.push_back(mkv(1, ins(5'b01000, 7, 1, 0), 0, 1, 0, 0, 0, 0, 0)); // load-use on rs
    tbl.push_back(mkv(1, ins(5'b01000, 7, 1, 0), 0, 0, 1, 1, 0, 0, 1)); // retry
    tbl.push_back(idle);
    tbl.push_back(idle);
    tbl.push_back(idle);
    for (int i = 0; i < tbl.size(); i++) cyc(tbl[i]);

    // Halt after two ALU ops: ID blocked afterwards, halted once it reaches WB.
    cyc(mkv(1, ins(5'b01000, 0, 1, 0), 0, 0, 1, 1, 0, 0, 1));
    cyc(mkv(1, ins(5'b01000, 1, 2, 0), 0, 0, 1, 1, 0, 0, 2));
    cyc(mkv(1, 16'h0000, 0, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) cyc(mkv(1, ins(5'b01000, 0, 3, 0), 0, 0, 0, 0, 0, 0, 0));
    cyc(mkv(0, 16'h0000, 0, 0, 0, 0, 0, 0, 0));

    // Reset with halted set, then with three valid stages.
    do_reset();
    cyc(mkv(1, ins(5'b01000, 0, 1, 0), 0, 0, 1, 1, 0, 0, 1));
    cyc(mkv(1, ins(5'b01000, 0, 2, 0), 0, 0, 1, 1, 0, 0, 2));
    cyc(mkv(1, ins(5'b01000, 0, 3, 0), 0, 0, 1, 1, 0, 0, 3));
    chk("t6_full", {ex_valid, mem_valid, wb_valid}, 3'b111);
    do_reset();
    cyc(mkv(1, ins(5'b01000, 0, 5, 0), 0, 0, 1, 1, 0, 0, 5));
    for (int i = 0; i < 3; i++) cyc(idle);

    // FWD_MEM=0: RAW against EX then against MEM -> two stall cycles.
    do_reset();
    id_valid = 1'b1; flush = 1'b0; id_instr = ins(5'b01000, 0, 4, 0);
    @(negedge clk); chk("t3_addi_stall", d0_stall, 0);
    @(posedge clk); #1;
    id_instr = ins(5'b10000, 1, 4, 0);
    @(negedge clk);
    chk("t3_ex_hit_stall", d0_stall, 1);
    chk("t3_ex_hit_ready", d0_id_ready, 0);
    chk("t3_fwd_nostall", stall, 0);
    @(posedge clk); #1; chk("t3_bubble1", d0_ex_valid, 0);
    @(negedge clk); chk("t3_mem_hit_stall", d0_stall, 1);
    @(posedge clk); #1; chk("t3_bubble2", d0_ex_valid, 0);
    @(negedge clk); chk("t3_clear", d0_stall, 0);
    @(posedge clk); #1;
    chk("t3_st_ex", {d0_ex_valid, d0_ex_mem_write, d0_ex_dest}, {1'b1, 1'b1, 3'd4});
    id_valid = 1'b0;
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
